// File: rtl/mano_datapath.sv
// mano_datapath: register datapath of the Mano basic computer.
// AR, PC, DR, AC and IR share one 16-bit common bus. A sequencer drives an
// 18-bit control word (CON) each cycle.
// Optional feature: define MANO_DP_E_FLAG_EN to keep the carry flag E written
// by ADD. Without it, the carry is dropped and e_flag is tied low.
module mano_datapath (
  input  logic        clk,
  input  logic        clr,
  input  logic [17:0] CON,
  input  logic [15:0] mem_rdata,
  output logic [2:0]  op_code,
  output logic [11:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  output logic [15:0] ac,
  output logic [11:0] pc,
  output logic        e_flag
);

  localparam int DATA_W = 16;
  localparam int ADDR_W = 12;

  logic [ADDR_W-1:0] ar_q;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] dr_q;
  logic [DATA_W-1:0] ac_q;
  logic [DATA_W-1:0] ir_q;
  logic [DATA_W-1:0] bus;
  logic [DATA_W:0]   alu_res;
  logic              unused_bits;

  // Control word fields; CON[7:4] is reserved.
  logic [2:0] sel;
  logic       skz, ld_ac, inr_dr, ld_dr, inr_pc, inr_ar, ld_ar, ld_ir, ld_pc;

  assign sel    = CON[2:0];
  assign skz    = CON[3];
  assign ld_ac  = CON[8];
  assign inr_dr = CON[9];
  assign ld_dr  = CON[10];
  assign inr_pc = CON[11];
  assign mem_re = CON[12];
  assign mem_we = CON[13];
  assign inr_ar = CON[14];
  assign ld_ar  = CON[15];
  assign ld_ir  = CON[16];
  assign ld_pc  = CON[17];

  // The ALU returns a 17-bit result; bit 16 is the ADD carry.
  function automatic logic [DATA_W:0] alu_f(input logic [2:0]        op,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] d);
    logic [DATA_W:0] r;
    case (op)
      3'b000:  r = {1'b0, a & d};
      3'b001:  r = {1'b0, a} + {1'b0, d};
      default: r = {1'b0, d};
    endcase
    return r;
  endfunction

  // The common bus multiplexer also drives the memory write data.
  always_comb begin
    bus = '0;
    case (sel)
      3'd1:    bus = {4'h0, ar_q};
      3'd2:    bus = {4'h0, pc_q};
      3'd3:    bus = dr_q;
      3'd4:    bus = ac_q;
      3'd5:    bus = ir_q;
      3'd7:    bus = mem_rdata;
      default: bus = '0;
    endcase
  end

  assign alu_res   = alu_f(ir_q[14:12], ac_q, dr_q);
  assign op_code   = ir_q[14:12];
  assign mem_addr  = ar_q;
  assign mem_wdata = bus;
  assign ac        = ac_q;
  assign pc        = pc_q;

  // AR: a load takes priority over an increment.
  always_ff @(posedge clk or posedge clr) begin
    if (clr)         ar_q <= '0;
    else if (ld_ar)  ar_q <= bus[ADDR_W-1:0];
    else if (inr_ar) ar_q <= ar_q + 12'd1;
  end

  // PC: a load wins. SKZ on a zero DR merges with INR_PC into a single +1.
  always_ff @(posedge clk or posedge clr) begin
    if (clr)                                pc_q <= '0;
    else if (ld_pc)                         pc_q <= bus[ADDR_W-1:0];
    else if (inr_pc || (skz && dr_q == '0)) pc_q <= pc_q + 12'd1;
  end

  // DR: a load takes priority over an increment.
  always_ff @(posedge clk or posedge clr) begin
    if (clr)         dr_q <= '0;
    else if (ld_dr)  dr_q <= bus;
    else if (inr_dr) dr_q <= dr_q + 16'd1;
  end

  // AC: loads the ALU result, with the operation selected by the IR opcode.
  always_ff @(posedge clk or posedge clr) begin
    if (clr)        ac_q <= '0;
    else if (ld_ac) ac_q <= alu_res[DATA_W-1:0];
  end

  // IR: loads from the bus.
  always_ff @(posedge clk or posedge clr) begin
    if (clr)        ir_q <= '0;
    else if (ld_ir) ir_q <= bus;
  end

`ifdef MANO_DP_E_FLAG_EN
  logic e_q;

  // E: only ADD updates the carry; AND and pass-through leave it alone.
  always_ff @(posedge clk or posedge clr) begin
    if (clr)                                  e_q <= 1'b0;
    else if (ld_ac && ir_q[14:12] == 3'b001)  e_q <= alu_res[DATA_W];
  end

  assign e_flag      = e_q;
  assign unused_bits = ^CON[7:4];
`else
  assign e_flag      = 1'b0;
  assign unused_bits = ^{CON[7:4], alu_res[DATA_W]};
`endif

endmodule

// File: doc/mano_datapath.md
MANO_DATAPATH -- requirements
Module: mano_datapath

Interface
REQ-001 clk  input  1  single clock; all registers update on its rising edge.
REQ-002 clr  input  1  reset, asynchronous, active-high.
REQ-003 CON  input  18  control word from the sequencer, sampled every clk rising edge.
REQ-004 op_code  output  3  IR[14:12], combinational from IR.
REQ-005 mem_addr  output  12  always equals AR.
REQ-006 mem_wdata  output  16  always equals the common bus value.
REQ-007 mem_we  output  1  equals CON[13].
REQ-008 mem_re  output  1  equals CON[12].
REQ-009 mem_rdata  input  16  memory read data, combinational w.r.t. mem_addr.
REQ-010 ac  output  16  accumulator value.
REQ-011 pc  output  12  program counter value.
REQ-012 e_flag  output  1  carry flag E.

Function
REQ-013 CON fields SHALL be: [2:0] SEL bus source; [3] SKZ; [7:4] reserved, ignored; [8] LD_AC; [9] INR_DR; [10] LD_DR; [11] INR_PC; [12] MEM_RD; [13] MEM_WR; [14] INR_AR; [15] LD_AR; [16] LD_IR; [17] LD_PC.
REQ-014 Bus SHALL be: SEL 0 -> 16'h0000; 1 -> {4'h0,AR}; 2 -> {4'h0,PC}; 3 -> DR; 4 -> AC; 5 -> IR; 6 -> 16'h0000; 7 -> mem_rdata.
REQ-015 Registers SHALL be AR[11:0], PC[11:0], DR[15:0], AC[15:0], IR[15:0], E; there is no TR.
REQ-016 LD_AR loads bus[11:0]; LD_PC loads bus[11:0]; LD_IR and LD_DR load bus[15:0]; all take effect at the next clk edge.
REQ-017 INR_AR, INR_PC, INR_DR increment by one modulo register width (AR/PC 12'hFFF -> 12'h000, DR 16'hFFFF -> 16'h0000).
REQ-018 On any one register, load and increment in the same cycle: load wins.
REQ-019 Several registers loading from the bus in one cycle all receive the same pre-edge bus value.
REQ-020 LD_AC loads the ALU result selected by IR[14:12] as sampled before the edge: 000 -> AC & DR; 001 -> AC + DR (17-bit sum, low 16 bits to AC); any other value -> DR.
REQ-021 ALU AND and pass-through SHALL leave E unchanged.
REQ-022 SKZ asserted while DR == 16'h0000 (pre-edge value) increments PC; it is ignored if LD_PC is also set; SKZ together with INR_PC increments PC by one, not two.
REQ-023 MEM_WR and MEM_RD together SHALL be passed to memory unchanged; the datapath does not arbitrate them.
REQ-024 CON == 18'h00000 SHALL hold every register.

Reset
REQ-025 While clr is high, AR, PC, DR, AC, IR and E SHALL be 0, so op_code = 3'b000, ac = 0, pc = 0, mem_addr = 0.
REQ-026 clr asserted mid-cycle SHALL clear immediately, with no clock needed, and SHALL discard that cycle's pending CON actions.
REQ-027 The first edge after clr deasserts SHALL execute the CON present at that edge.

Configuration
REQ-028 Macro MANO_DP_E_FLAG_EN defined: ADD SHALL write sum bit 16 into E.
REQ-029 Macro MANO_DP_E_FLAG_EN undefined: the carry is discarded, no E register exists, and e_flag is tied to 0.
REQ-030 The macro SHALL change no other behaviour.

Verification
REQ-031 Fetch: PC=12'h010, mem[010]=16'h2055, CON 18'h09002 then 18'h10807 then 18'h08005 -> IR=16'h2055, PC=12'h011, AR=12'h055, op_code=3'b010.
REQ-032 ADD with carry: AC=16'hFFFF, DR=16'h0002, IR[14:12]=001, CON 18'h00100 -> AC=16'h0001; E=1 with MANO_DP_E_FLAG_EN defined, E=0 without it.
REQ-033 Store: AC=16'hABCD, AR=12'h123, CON 18'h02004 -> mem_we=1, mem_addr=12'h123, mem_wdata=16'hABCD for one cycle; no register changes.
REQ-034 Increment and skip: DR=16'hFFFF, CON 18'h00200 -> DR=16'h0000; then CON 18'h00008 with PC=12'h020 -> PC=12'h021.
REQ-035 Wrap and priority: PC=12'hFFF with CON INR_PC -> PC=12'h000; LD_PC+INR_PC with AR=12'h077 and SEL=1 -> PC=12'h077.
REQ-036 Async reset: clr pulsed between edges while AC=16'h5A5A -> AC reads 0 before the next edge, and the following CON executes normally after release.
